mdv_writer: RTL and testbench

//  Microdrive write path: the transmit-side counterpart of the microdrive replay logic.
//  - Accepts bytes the CPU writes to the microdrive transmit register.
//  - Paces them at the 200 kbit/s tape rate and packs them into 16-bit words.
//  - Writes the words back into the cartridge image in upper RAM (>16MB) through a
//    req/ack write port, so the replay path later reads them back.

---
 rtl/mdv_writer_if.sv | 18 +
 rtl/mdv_writer.sv | 264 ++++++++++++++++++++++++++
 tb/tb_mdv_writer.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdv_writer_if.sv
// ============================================================================
//  Module      : mdv_writer_if
//  Description : Word write port from the microdrive writer into upper RAM.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mdv_writer_if;
    logic        mem_req;
    logic [24:0] mem_addr;
    logic [15:0] mem_dout;
    logic        mem_ack;

    modport master (output mem_req, output mem_addr, output mem_dout, input mem_ack);
    modport slave  (input mem_req, input mem_addr, input mem_dout, output mem_ack);
endinterface

`default_nettype wire

// File: rtl/mdv_writer.sv
// ============================================================================
//  Module      : mdv_writer
//  Description : Microdrive write path. Paces CPU bytes at the tape bit rate,
//                packs them into 16-bit words and writes them into the
//                cartridge image. Optional macro: MDV_WR_PROTECT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdv_writer #(
    parameter int          CLK_HZ     = 21000000,
    parameter int          BIT_HZ     = 200000,
    parameter logic [24:0] BASE_ADDR  = 25'h800000,
    parameter int          FIFO_DEPTH = 2
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    input  wire logic        sel,
    input  wire logic        wr_en,
    input  wire logic [24:0] start_addr,
    input  wire logic [24:0] img_end,
    input  wire logic [7:0]  tx_data,
    input  wire logic        tx_load,
    output logic             tx_empty,
    output logic             busy,
    output logic             overrun,
`ifdef MDV_WR_PROTECT_EN
    input  wire logic        wr_protect,
    output logic             wp_hit,
`endif
    mdv_writer_if.master     mem
);

    localparam int c_bit_div     = CLK_HZ / BIT_HZ;
    localparam int c_byte_cycles = 8 * c_bit_div;
    localparam int c_cnt_w       = $clog2(c_byte_cycles);
    localparam int c_ptr_w       = $clog2(FIFO_DEPTH);
    localparam int c_last_int    = c_byte_cycles - 1;
    localparam int c_full_int    = FIFO_DEPTH;
    localparam logic [c_cnt_w-1:0] c_last = c_last_int[c_cnt_w-1:0];
    localparam logic [c_ptr_w:0]   c_full = c_full_int[c_ptr_w:0];

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SHIFT, S_FLUSH} state_t;

    state_t               state_q, state_d;
    logic                 wr_prev_q, wr_prev_d;
    logic [7:0]           hold_data_q, hold_data_d;
    logic                 hold_full_q, hold_full_d;
    logic [7:0]           shift_data_q, shift_data_d;
    logic [c_cnt_w-1:0]   bit_cnt_q, bit_cnt_d;
    logic                 stop_q, stop_d;
    logic                 odd_phase_q, odd_phase_d;
    logic [7:0]           hi_byte_q, hi_byte_d;
    logic [24:0]          wr_addr_q, wr_addr_d;
    logic                 overrun_q, overrun_d;
    logic [15:0]          fifo_data_q [FIFO_DEPTH];
    logic [15:0]          fifo_data_d [FIFO_DEPTH];
    logic [24:0]          fifo_addr_q [FIFO_DEPTH];
    logic [24:0]          fifo_addr_d [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w:0]     count_q, count_d;
`ifdef MDV_WR_PROTECT_EN
    logic                 wp_hit_q, wp_hit_d;
`endif

    logic                 w_wr_en;
    logic                 w_load;
    logic                 w_rise;
    logic                 w_pop;
    logic                 w_stop;
    logic                 push_req;
    logic                 push_ok;
    logic [15:0]          push_word;

    assign w_wr_en = sel & wr_en;
    assign w_load  = sel & tx_load;
    assign w_rise  = w_wr_en & ~wr_prev_q;
    assign w_pop   = mem.mem_ack & (count_q != '0);
    assign w_stop  = stop_q | ~w_wr_en;

    always_comb begin
        state_d      = state_q;
        wr_prev_d    = w_wr_en;
        hold_data_d  = hold_data_q;
        hold_full_d  = hold_full_q;
        shift_data_d = shift_data_q;
        bit_cnt_d    = bit_cnt_q;
        stop_d       = stop_q;
        odd_phase_d  = odd_phase_q;
        hi_byte_d    = hi_byte_q;
        wr_addr_d    = wr_addr_q;
        overrun_d    = overrun_q;
        fifo_data_d  = fifo_data_q;
        fifo_addr_d  = fifo_addr_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        push_req     = 1'b0;
        push_ok      = 1'b0;
        push_word    = '0;
`ifdef MDV_WR_PROTECT_EN
        wp_hit_d     = wp_hit_q;
`endif

        // CPU strobes only matter while a session is actually shifting
        if (w_load && (state_q == S_ARMED || state_q == S_SHIFT)) begin
            if (hold_full_q) begin
                overrun_d = 1'b1;
            end else begin
                hold_data_d = tx_data;
                hold_full_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (w_rise) begin
                    state_d     = S_ARMED;
                    wr_addr_d   = (start_addr < BASE_ADDR || start_addr > img_end) ?
                                  BASE_ADDR : start_addr;
                    overrun_d   = 1'b0;
                    odd_phase_d = 1'b0;
                    stop_d      = 1'b0;
`ifdef MDV_WR_PROTECT_EN
                    wp_hit_d    = 1'b0;
`endif
                end
            end
            S_ARMED: begin
                if (!w_wr_en) begin
                    if (odd_phase_q) begin
                        push_req  = 1'b1;
                        push_word = {hi_byte_q, 8'h00};
                    end
                    odd_phase_d = 1'b0;
                    hold_full_d = 1'b0;
                    state_d     = S_FLUSH;
                end else if (hold_full_q) begin
                    shift_data_d = hold_data_q;
                    hold_full_d  = 1'b0;
                    bit_cnt_d    = '0;
                    stop_d       = 1'b0;
                    state_d      = S_SHIFT;
                end
            end
            S_SHIFT: begin
                stop_d = w_stop;
                if (bit_cnt_q == c_last) begin
                    if (odd_phase_q) begin
                        push_req    = 1'b1;
                        push_word   = {hi_byte_q, shift_data_q};
                        odd_phase_d = 1'b0;
                    end else if (w_stop) begin
                        push_req  = 1'b1;
                        push_word = {shift_data_q, 8'h00};
                    end else begin
                        hi_byte_d   = shift_data_q;
                        odd_phase_d = 1'b1;
                    end
                    if (w_stop) begin
                        hold_full_d = 1'b0;
                        state_d     = S_FLUSH;
                    end else begin
                        state_d = S_ARMED;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase

        if (push_req) begin
`ifdef MDV_WR_PROTECT_EN
            if (wr_protect) begin
                wp_hit_d = 1'b1;
            end else
`endif
            if (count_q == c_full) begin
                overrun_d = 1'b1;
            end else begin
                push_ok               = 1'b1;
                fifo_data_d[wr_ptr_q] = push_word;
                fifo_addr_d[wr_ptr_q] = wr_addr_q;
                wr_ptr_d              = wr_ptr_q + 1'b1;
                wr_addr_d             = (wr_addr_q == img_end) ? BASE_ADDR : wr_addr_q + 25'd1;
            end
        end

        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && w_pop) begin
            count_d = count_q - 1'b1;
        end

        // Session ends on the same edge that pops the last buffered word
        if (state_q == S_FLUSH && count_d == '0) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            wr_prev_q    <= 1'b0;
            hold_data_q  <= '0;
            hold_full_q  <= 1'b0;
            shift_data_q <= '0;
            bit_cnt_q    <= '0;
            stop_q       <= 1'b0;
            odd_phase_q  <= 1'b0;
            hi_byte_q    <= '0;
            wr_addr_q    <= BASE_ADDR;
            overrun_q    <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_addr_q[i] <= BASE_ADDR;
            end
`ifdef MDV_WR_PROTECT_EN
            wp_hit_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wr_prev_q    <= wr_prev_d;
            hold_data_q  <= hold_data_d;
            hold_full_q  <= hold_full_d;
            shift_data_q <= shift_data_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_q       <= stop_d;
            odd_phase_q  <= odd_phase_d;
            hi_byte_q    <= hi_byte_d;
            wr_addr_q    <= wr_addr_d;
            overrun_q    <= overrun_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            fifo_data_q  <= fifo_data_d;
            fifo_addr_q  <= fifo_addr_d;
`ifdef MDV_WR_PROTECT_EN
            wp_hit_q     <= wp_hit_d;
`endif
        end
    end

    assign tx_empty     = ~hold_full_q;
    assign busy         = (state_q != S_IDLE);
    assign overrun      = overrun_q;
    assign mem.mem_req  = (count_q != '0);
    assign mem.mem_addr = (count_q != '0) ? fifo_addr_q[rd_ptr_q] : wr_addr_q;
    assign mem.mem_dout = fifo_data_q[rd_ptr_q];
`ifdef MDV_WR_PROTECT_EN
    assign wp_hit       = wp_hit_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mdv_writer.sv
// ============================================================================
//  Module      : tb_mdv_writer
//  Description : Directed self-checking bench for mdv_writer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mdv_writer;

    logic        clk;
    logic        reset_n;
    logic        sel;
    logic        wr_en;
    logic [24:0] start_addr;
    logic [24:0] img_end;
    logic [7:0]  tx_data;
    logic        tx_load;
    logic        tx_empty;
    logic        busy;
    logic        overrun;
`ifdef MDV_WR_PROTECT_EN
    logic        wr_protect;
    logic        wp_hit;
`endif

    mdv_writer_if mif ();

    mdv_writer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sel        (sel),
        .wr_en      (wr_en),
        .start_addr (start_addr),
        .img_end    (img_end),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .tx_empty   (tx_empty),
        .busy       (busy),
        .overrun    (overrun),
`ifdef MDV_WR_PROTECT_EN
        .wr_protect (wr_protect),
        .wp_hit     (wp_hit),
`endif
        .mem        (mif.master)
    );

    int          errors = 0;
    int          checks = 0;
    bit          ack_en = 1'b1;
    int          log_n  = 0;
    logic [24:0] log_addr [16];
    logic [15:0] log_data [16];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory slave: one-cycle ack per request, records every accepted write
    initial begin
        mif.mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (mif.mem_ack) begin
                mif.mem_ack = 1'b0;
            end else if (ack_en && mif.mem_req && reset_n) begin
                if (log_n < 16) begin
                    log_addr[log_n] = mif.mem_addr;
                    log_data[log_n] = mif.mem_dout;
                end
                log_n = log_n + 1;
                mif.mem_ack = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (!tx_empty && n < 3000) begin
            tick(1);
            n++;
        end
        if (!tx_empty) begin
            checks++; errors++;
            $display("FAIL tx_empty_wait: tx_empty=%0b required 1", tx_empty);
        end
        tx_data = b;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (!tx_empty && n < 3000) begin
            tick(1);
            n++;
        end
        if (!tx_empty) begin
            checks++; errors++;
            $display("FAIL tx_empty_wait: tx_empty=%0b required 1", tx_empty);
        end
    endtask

    task automatic start_session(input logic [24:0] sa, input logic [24:0] ie);
        log_n      = 0;
        start_addr = sa;
        img_end    = ie;
        wr_en      = 1'b1;
        tick(2);
    endtask

    task automatic end_session();
        int n = 0;
        wr_en = 1'b0;
        while (busy && n < 5000) begin
            tick(1);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_fall: busy=%0b required 0", busy);
        end
    endtask

    task automatic expect_write(input int idx, input logic [24:0] a, input logic [15:0] d);
        checks++;
        if (log_n <= idx || log_addr[idx] !== a || log_data[idx] !== d) begin
            errors++;
            $display("FAIL write%0d: got %0d writes addr=%h data=%h required addr=%h data=%h",
                     idx, log_n, log_addr[idx], log_data[idx], a, d);
        end
    endtask

    task automatic expect_count(input string name, input int req);
        checks++;
        if (log_n !== req) begin
            errors++;
            $display("FAIL %s: writes=%0d required %0d", name, log_n, req);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(3);
        checks += 6;
        if (tx_empty !== 1'b1) begin errors++; $display("FAIL rst_tx_empty: %0b required 1", tx_empty); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: %0b required 0", busy); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: %0b required 0", overrun); end
        if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: %0b required 0", mif.mem_req); end
        if (mif.mem_addr !== 25'h800000) begin errors++; $display("FAIL rst_mem_addr: %h required 800000", mif.mem_addr); end
        if (mif.mem_dout !== 16'h0000) begin errors++; $display("FAIL rst_mem_dout: %h required 0000", mif.mem_dout); end
        @(negedge clk);
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_idle_load();
        tx_data = 8'h77;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
        tick(1);
        checks += 2;
        if (tx_empty !== 1'b1) begin errors++; $display("FAIL idle_load_tx_empty: %0b required 1", tx_empty); end
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_load_busy: %0b required 0", busy); end
    endtask

    task automatic test_single_word();
        start_session(25'h800010, 25'h8FFFFF);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy: %0b required 1", busy); end
        send_byte(8'hA5);
        send_byte(8'h5A);
        wait_empty();
        end_session();
        expect_count("t1_count", 1);
        expect_write(0, 25'h800010, 16'hA55A);
        checks += 2;
        if (overrun !== 1'b0) begin errors++; $display("FAIL t1_overrun: %0b required 0", overrun); end
        if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL t1_mem_req: %0b required 0", mif.mem_req); end
    endtask

    task automatic test_odd_tail();
        start_session(25'h800020, 25'h8FFFFF);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        wait_empty();
        end_session();
        expect_count("t2_count", 2);
        expect_write(0, 25'h800020, 16'h1122);
        expect_write(1, 25'h800021, 16'h3300);
    endtask

    task automatic test_overrun_byte();
        start_session(25'h800040, 25'h8FFFFF);
        send_byte(8'h10);
        send_byte(8'h20);
        tick(9);
        tx_data = 8'h30;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
        tick(1);
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL t3_overrun: %0b required 1", overrun); end
        wait_empty();
        end_session();
        expect_count("t3_count", 1);
        expect_write(0, 25'h800040, 16'h1020);
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL t3_overrun_sticky: %0b required 1", overrun); end
    endtask

    task automatic test_wrap_and_clamp();
        start_session(25'h800003, 25'h800003);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        wait_empty();
        end_session();
        expect_count("t4_count", 2);
        expect_write(0, 25'h800003, 16'hAABB);
        expect_write(1, 25'h800000, 16'hCCDD);
        start_session(25'h7FFFF0, 25'h8FFFFF);
        send_byte(8'h01);
        send_byte(8'h02);
        wait_empty();
        end_session();
        expect_count("clamp_count", 1);
        expect_write(0, 25'h800000, 16'h0102);
    endtask

    task automatic test_fifo_full();
        ack_en = 1'b0;
        start_session(25'h800100, 25'h8FFFFF);
        for (int i = 1; i <= 6; i++) begin
            send_byte(8'(i));
        end
        wait_empty();
        tick(860);
        checks += 3;
        if (overrun !== 1'b1) begin errors++; $display("FAIL t5_overrun: %0b required 1", overrun); end
        if (mif.mem_req !== 1'b1) begin errors++; $display("FAIL t5_mem_req: %0b required 1", mif.mem_req); end
        if (log_n !== 0) begin errors++; $display("FAIL t5_no_ack: writes=%0d required 0", log_n); end
        ack_en = 1'b1;
        send_byte(8'h07);
        send_byte(8'h08);
        wait_empty();
        end_session();
        expect_count("t5_count", 3);
        expect_write(0, 25'h800100, 16'h0102);
        expect_write(1, 25'h800101, 16'h0304);
        expect_write(2, 25'h800102, 16'h0708);
    endtask

    task automatic test_async_reset();
        ack_en = 1'b0;
        start_session(25'h800200, 25'h8FFFFF);
        send_byte(8'h41);
        send_byte(8'h42);
        send_byte(8'h43);
        wait_empty();
        checks++;
        if (mif.mem_req !== 1'b1) begin errors++; $display("FAIL t6_pre_req: %0b required 1", mif.mem_req); end
        #3;
        reset_n = 1'b0;
        #1;
        checks += 4;
        if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL t6_mem_req: %0b required 0", mif.mem_req); end
        if (tx_empty !== 1'b1) begin errors++; $display("FAIL t6_tx_empty: %0b required 1", tx_empty); end
        if (busy !== 1'b0) begin errors++; $display("FAIL t6_busy: %0b required 0", busy); end
        if (mif.mem_addr !== 25'h800000) begin errors++; $display("FAIL t6_mem_addr: %h required 800000", mif.mem_addr); end
        wr_en = 1'b0;
        tick(2);
        @(negedge clk);
        reset_n = 1'b1;
        ack_en  = 1'b1;
        tick(2);
    endtask

`ifdef MDV_WR_PROTECT_EN
    task automatic test_protect();
        wr_protect = 1'b1;
        start_session(25'h800300, 25'h8FFFFF);
        send_byte(8'h55);
        send_byte(8'h66);
        wait_empty();
        end_session();
        expect_count("wp_count", 0);
        checks++;
        if (wp_hit !== 1'b1) begin errors++; $display("FAIL wp_hit: %0b required 1", wp_hit); end
        wr_protect = 1'b0;
    endtask
`endif

    initial begin
        reset_n    = 1'b0;
        sel        = 1'b1;
        wr_en      = 1'b0;
        start_addr = 25'h800000;
        img_end    = 25'h8FFFFF;
        tx_data    = 8'h00;
        tx_load    = 1'b0;
`ifdef MDV_WR_PROTECT_EN
        wr_protect = 1'b0;
`endif
        test_reset();
        test_idle_load();
        test_single_word();
        test_odd_tail();
        test_overrun_byte();
        test_wrap_and_clamp();
        test_fifo_full();
        test_async_reset();
`ifdef MDV_WR_PROTECT_EN
        test_protect();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
